regfile_dump: RTL and testbench

Debug read-out engine for the 16 x 16-bit register file. On command it walks an inclusive, wrapping address range through one register-file read port and streams each register as two bytes over a valid/ready byte channel, for example to a UART TX or a trace buffer. It is the reader counterpart to the datapath's write port. It borrows the read port only while the datapath grants it.

---
 rtl/regfile_dump.sv | 140 ++++++++++++++
 tb/tb_regfile_dump.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// regfile_dump: debug read-out engine for a 16 x 16-bit register file.
// Walks an inclusive, wrapping address range through one borrowed read
// port and streams every register as two bytes over a valid/ready channel.
module regfile_dump #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  first_addr,
    input  logic [3:0]  last_addr,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [3:0]  rdAddr,
    input  logic [15:0] rdData,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_SEND_A,
        S_SEND_B,
        S_DONE
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cur_q;
    logic [3:0]  last_q;
    logic [15:0] data_q;
    logic        at_last;
    logic        handshake;

    assign at_last   = (cur_q == last_q);
    assign handshake = out_valid & out_ready;
    assign rdAddr    = cur_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE, grant only in REQ.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus_gnt) begin
                    state_d = S_SEND_A;
                end
            end
            S_SEND_A: begin
                if (handshake) begin
                    state_d = S_SEND_B;
                end
            end
            S_SEND_B: begin
                if (handshake) begin
                    state_d = at_last ? S_DONE : S_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Range capture, address advance and read-data snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q  <= '0;
            last_q <= '0;
            data_q <= '0;
        end else begin
            if (state_q == S_IDLE && start) begin
                cur_q  <= first_addr;
                last_q <= last_addr;
            end
            if (state_q == S_REQ && bus_gnt) begin
                data_q <= rdData;
            end
            // 4-bit add wraps 15 -> 0, which gives the wrapping range for free.
            if (state_q == S_SEND_B && handshake && !at_last) begin
                cur_q <= cur_q + 4'd1;
            end
        end
    end

    // Outputs decoded from state and held registers only (no ready -> valid path).
    always_comb begin
        bus_req   = 1'b0;
        out_valid = 1'b0;
        out_byte  = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            S_REQ: begin
                bus_req = 1'b1;
                busy    = 1'b1;
            end
            S_SEND_A: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_byte  = MSB_FIRST ? data_q[15:8] : data_q[7:0];
            end
            S_SEND_B: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_byte  = MSB_FIRST ? data_q[7:0] : data_q[15:8];
                out_last  = at_last;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Testbench for regfile_dump: two instances (high byte first / low byte
// first) share stimulus; a scoreboard of expected bytes is filled when a
// scan is launched and drained by a monitor on every accepted byte.
module tb_regfile_dump;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  first_addr;
    logic [3:0]  last_addr;
    logic        bus_gnt;
    logic        out_ready;
    logic [15:0] rf [16];

    logic        req_m, valid_m, last_m, busy_m, done_m;
    logic [3:0]  addr_m;
    logic [7:0]  byte_m;
    logic [15:0] rdata_m;
    logic        req_l, valid_l, last_l, busy_l, done_l;
    logic [3:0]  addr_l;
    logic [7:0]  byte_l;
    logic [15:0] rdata_l;

    assign rdata_m = rf[addr_m];
    assign rdata_l = rf[addr_l];

    regfile_dump #(.MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .start(start),
        .first_addr(first_addr), .last_addr(last_addr),
        .bus_req(req_m), .bus_gnt(bus_gnt), .rdAddr(addr_m), .rdData(rdata_m),
        .out_valid(valid_m), .out_ready(out_ready), .out_byte(byte_m),
        .out_last(last_m), .busy(busy_m), .done(done_m)
    );

    regfile_dump #(.MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .start(start),
        .first_addr(first_addr), .last_addr(last_addr),
        .bus_req(req_l), .bus_gnt(bus_gnt), .rdAddr(addr_l), .rdData(rdata_l),
        .out_valid(valid_l), .out_ready(out_ready), .out_byte(byte_l),
        .out_last(last_l), .busy(busy_l), .done(done_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // {byte, last} entries
    logic [8:0] q_m[$];
    logic [8:0] q_l[$];
    logic       stall [2];
    logic [7:0] pb [2];
    logic       pl [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mon(input int d, input logic v, input logic [7:0] b, input logic l);
        string n;
        logic [8:0] e;
        int sz;
        n = (d == 0) ? "msb" : "lsb";
        if (!v) chk({n, "_idle_byte"}, {24'h0, b}, 32'h0);
        if (stall[d]) begin
            chk({n, "_stall_valid"}, {31'h0, v}, 32'h1);
            chk({n, "_stall_byte"}, {24'h0, b}, {24'h0, pb[d]});
            chk({n, "_stall_last"}, {31'h0, l}, {31'h0, pl[d]});
        end
        if (v && out_ready) begin
            sz = (d == 0) ? q_m.size() : q_l.size();
            chk({n, "_byte_expected"}, {31'h0, (sz > 0)}, 32'h1);
            if (sz > 0) begin
                e = (d == 0) ? q_m.pop_front() : q_l.pop_front();
                chk({n, "_byte"}, {24'h0, b}, {24'h0, e[8:1]});
                chk({n, "_last"}, {31'h0, l}, {31'h0, e[0]});
            end
        end
        stall[d] = v && !out_ready;
        pb[d]    = b;
        pl[d]    = l;
    endtask

    // Monitor, sampled mid-low-phase after stimulus has settled.
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            stall[0] = 1'b0;
            stall[1] = 1'b0;
        end else begin
            mon(0, valid_m, byte_m, last_m);
            mon(1, valid_l, byte_l, last_l);
        end
    end

    task automatic push_exp(input logic [3:0] f, input logic [3:0] l,
                            input bit wr_en, input logic [3:0] wi, input logic [15:0] wv);
        logic [3:0]  span;
        logic [3:0]  idx;
        logic [15:0] d;
        logic        lst;
        int unsigned n;
        span = l - f;
        n = int'(span) + 1;
        for (int unsigned k = 0; k < n; k++) begin
            idx = f + 4'(k);
            d   = (wr_en && idx == wi) ? wv : rf[idx];
            lst = (k == n - 1);
            q_m.push_back({d[15:8], 1'b0});
            q_m.push_back({d[7:0], lst});
            q_l.push_back({d[7:0], 1'b0});
            q_l.push_back({d[15:8], lst});
        end
    endtask

    task automatic scan(input string tag, input logic [3:0] f, input logic [3:0] l,
                        input int gnt_hold, input bit rand_rdy, input bit hold_start,
                        input bit pulse, input bit wr_en, input logic [3:0] wi,
                        input logic [15:0] wv, input int exp_cyc);
        int cyc;
        bit seen;
        push_exp(f, l, wr_en, wi, wv);
        @(negedge clk);
        start      = 1'b1;
        first_addr = f;
        last_addr  = l;
        bus_gnt    = (gnt_hold == 0);
        out_ready  = 1'b1;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (!hold_start && !pulse) start = 1'b0;
            if (pulse && cyc == 1) start = 1'b0;
            if (pulse && cyc == 4) begin
                start      = 1'b1;
                first_addr = 4'h0;
                last_addr  = 4'hF;
            end
            if (pulse && cyc == 5) start = 1'b0;
            if (gnt_hold > 0 && cyc <= gnt_hold) begin
                chk({tag, "_req_msb"}, {31'h0, req_m}, 32'h1);
                chk({tag, "_req_lsb"}, {31'h0, req_l}, 32'h1);
            end
            if (cyc == gnt_hold + 1) bus_gnt = 1'b1;
            if (wr_en && cyc == 5) rf[wi] = wv;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            if (done_m) begin
                seen = 1'b1;
                chk({tag, "_done_lsb"}, {31'h0, done_l}, 32'h1);
                chk({tag, "_busy_at_done"}, {31'h0, busy_m}, 32'h0);
            end
        end
        chk({tag, "_done_seen"}, {31'h0, seen}, 32'h1);
        if (exp_cyc >= 0) chk({tag, "_done_cycle"}, cyc, exp_cyc);
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_busy_after"}, {30'h0, busy_m, busy_l}, 32'h0);
        chk({tag, "_done_pulse"}, {30'h0, done_m, done_l}, 32'h0);
        chk({tag, "_sb_empty"}, q_m.size() + q_l.size(), 32'h0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl_msb"}, {27'h0, req_m, valid_m, last_m, busy_m, done_m}, 32'h0);
        chk({tag, "_ctrl_lsb"}, {27'h0, req_l, valid_l, last_l, busy_l, done_l}, 32'h0);
        chk({tag, "_data"}, {16'h0, byte_m, byte_l}, 32'h0);
        chk({tag, "_addr"}, {24'h0, addr_m, addr_l}, 32'h0);
    endtask

    initial begin
        bit got;
        for (int i = 0; i < 16; i++) rf[i] = 16'hA000 + 16'(i);
        stall[0] = 1'b0; stall[1] = 1'b0;
        rst_n = 1'b0; start = 1'b0; first_addr = 4'h0; last_addr = 4'h0;
        bus_gnt = 1'b1; out_ready = 1'b1;
        #3;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        scan("full",   4'h0, 4'hF, 0,  1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 49);
        scan("wrap",   4'hE, 4'h1, 0,  1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 13);
        scan("bp",     4'h0, 4'hF, 0,  1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0, -1);
        scan("bpwrap", 4'h6, 4'h5, 0,  1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0, -1);
        scan("starve", 4'h3, 4'h3, 10, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 16'h1234, 14);
        scan("hold",   4'h9, 4'h9, 0,  1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0, 4);
        repeat (4) begin
            @(negedge clk);
            chk("hold_no_restart", {30'h0, busy_m, busy_l}, 32'h0);
        end
        scan("pulse",  4'h7, 4'h8, 0,  1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 16'h0, 7);

        // Reset while the second byte of a register is pending.
        q_m.push_back({8'hA0, 1'b0});
        q_l.push_back({8'h09, 1'b0});
        @(negedge clk);
        out_ready = 1'b0; start = 1'b1; first_addr = 4'h9; last_addr = 4'hC;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            start = 1'b0;
            got = valid_m;
        end
        chk("rst_wait_valid", {31'h0, got}, 32'h1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("rst_sendb_byte", {16'h0, byte_m, byte_l}, 32'h09A0);
        chk("rst_sendb_valid", {30'h0, valid_m, valid_l}, 32'h3);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        q_m.delete();
        q_l.delete();
        repeat (3) @(negedge clk);
        chk_zero("rst_held");
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_abandoned", {28'h0, valid_m, valid_l, done_m, done_l}, 32'h0);
        end
        scan("after_rst", 4'h5, 4'h5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 4);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
